// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: synchronizes the raw TX pad, samples each bit at its mid-point
// and emits one byte per good frame with a single-cycle valid strobe.
module uart_rx_deserializer #(
    parameter int BAUD_DIV    = 434,
    parameter int SYNC_STAGES = 2
) (
    input  logic       theclk,
    input  logic       theresetn,
    input  logic       rx,
    output logic [7:0] uart_data,
    output logic       uart_data_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int CW = $clog2(BAUD_DIV);
    // The tick counter counts down to zero, so an N-cycle interval loads N-1.
    localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [CW-1:0]          tick_cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             shreg;
    logic                   tick_done;
    logic                   load_half;
    logic                   load_full;
    logic                   clear_idx;
    logic                   shift_en;
    logic                   good_stop;
    logic                   bad_stop;

    // Synchronizer resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge theclk or negedge theresetn) begin
        if (!theresetn) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign tick_done = (tick_cnt == '0);

    always_ff @(posedge theclk or negedge theresetn) begin
        if (!theresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!rx_s) state_next = START;
            START:   if (tick_done) state_next = rx_s ? IDLE : DATA;
            DATA:    if (tick_done && (bit_idx == 3'd7)) state_next = STOP;
            STOP:    if (tick_done) state_next = rx_s ? IDLE : BRK;
            BRK:     if (rx_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rx_busy   = (state != IDLE);
        load_half = (state == IDLE) && !rx_s;
        clear_idx = (state == START) && tick_done && !rx_s;
        shift_en  = (state == DATA) && tick_done;
        load_full = clear_idx || shift_en;
        good_stop = (state == STOP) && tick_done && rx_s;
        bad_stop  = (state == STOP) && tick_done && !rx_s;
    end

    always_ff @(posedge theclk or negedge theresetn) begin
        if (!theresetn) begin
            tick_cnt        <= '0;
            bit_idx         <= 3'd0;
            shreg           <= 8'h00;
            uart_data       <= 8'h00;
            uart_data_valid <= 1'b0;
            frame_err       <= 1'b0;
        end else begin
            if (load_half) begin
                tick_cnt <= HALF_LOAD;
            end else if (load_full) begin
                tick_cnt <= FULL_LOAD;
            end else if (!tick_done) begin
                tick_cnt <= tick_cnt - CW'(1);
            end

            if (clear_idx) begin
                bit_idx <= 3'd0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 3'd1;
            end

            // LSB arrives first, so after eight right shifts it sits at bit 0.
            if (shift_en) begin
                shreg <= {rx_s, shreg[7:1]};
            end

            if (good_stop) begin
                uart_data <= shreg;
            end
            uart_data_valid <= good_stop;
            frame_err       <= bad_stop;
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Randomized bench for uart_rx_deserializer: byte scoreboard, latency/spacing
// arithmetic from the frame format, glitch, break, async reset and baud skew.
`timescale 1ns/1ps
module tb_uart_rx_deserializer;

    localparam int  SYNC    = 2;
    localparam int  B8      = 8;
    localparam int  B16     = 16;
    localparam real BIT8_NS = 80.0;

    logic       theclk = 1'b0;
    logic       theresetn = 1'b0;
    logic       rx8 = 1'b1;
    logic       rx16 = 1'b1;
    logic [7:0] data8, data16;
    logic       valid8, valid16, err8, err16, busy8, busy16;

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         strobe_cnt = 0, err_cnt = 0, strobe16_cnt = 0, err16_cnt = 0;
    int         strobe_cyc[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp16_q[$];

    always #5 theclk = ~theclk;
    always @(posedge theclk) cyc <= cyc + 1;

    uart_rx_deserializer #(.BAUD_DIV(B8), .SYNC_STAGES(SYNC)) dut8 (
        .theclk(theclk), .theresetn(theresetn), .rx(rx8), .uart_data(data8),
        .uart_data_valid(valid8), .frame_err(err8), .rx_busy(busy8));

    uart_rx_deserializer #(.BAUD_DIV(B16), .SYNC_STAGES(SYNC)) dut16 (
        .theclk(theclk), .theresetn(theresetn), .rx(rx16), .uart_data(data16),
        .uart_data_valid(valid16), .frame_err(err16), .rx_busy(busy16));

    // Monitor for the BAUD_DIV=8 instance: scoreboard, exclusion and hold checks.
    initial begin : mon8
        logic [7:0] prev;
        logic [7:0] exp;
        prev = 8'h00;
        forever begin
            @(negedge theclk);
            if (theresetn) begin
                if (valid8 && err8) begin
                    vectors++; miscompares++;
                    $display("FAIL excl8: valid=1 frame_err=1, required not both");
                end
                if (valid8) begin
                    strobe_cnt++;
                    strobe_cyc.push_back(cyc);
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected8: strobe with data %02h, none expected", data8);
                    end else begin
                        exp = exp_q.pop_front();
                        if (data8 !== exp) begin
                            miscompares++;
                            $display("FAIL data8: got %02h, expected %02h", data8, exp);
                        end
                    end
                end
                if (err8) err_cnt++;
                if (data8 !== prev) begin
                    vectors++;
                    if (!valid8) begin
                        miscompares++;
                        $display("FAIL hold8: data changed %02h->%02h without strobe", prev, data8);
                    end
                end
            end
            prev = data8;
        end
    end

    initial begin : mon16
        logic [7:0] exp;
        forever begin
            @(negedge theclk);
            if (theresetn) begin
                if (valid16) begin
                    strobe16_cnt++;
                    vectors++;
                    if (exp16_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected16: strobe with data %02h, none expected", data16);
                    end else begin
                        exp = exp16_q.pop_front();
                        if (data16 !== exp) begin
                            miscompares++;
                            $display("FAIL data16: got %02h, expected %02h", data16, exp);
                        end
                    end
                end
                if (err16) err16_cnt++;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic send_frame8(input logic [7:0] b, input logic stop_bit);
        rx8 = 1'b0; #(BIT8_NS);
        for (int i = 0; i < 8; i++) begin
            rx8 = b[i]; #(BIT8_NS);
        end
        rx8 = stop_bit; #(BIT8_NS);
    endtask

    task automatic send_frame16(input logic [7:0] b, input real per_ns);
        rx16 = 1'b0; #(per_ns);
        for (int i = 0; i < 8; i++) begin
            rx16 = b[i]; #(per_ns);
        end
        rx16 = 1'b1; #(per_ns);
    endtask

    task automatic wait_drain(input int budget);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || exp16_q.size() != 0) && i < budget) begin
            @(negedge theclk);
            i++;
        end
        vectors++;
        if (exp_q.size() != 0 || exp16_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d/%0d bytes still pending, required 0", exp_q.size(), exp16_q.size());
            exp_q.delete();
            exp16_q.delete();
        end
    endtask

    task automatic test_reset();
        theresetn = 1'b0;
        @(negedge theclk);
        vectors++;
        if ({data8, valid8, err8, busy8} !== 11'd0) begin
            miscompares++;
            $display("FAIL reset8: outputs %03h, required 000", {data8, valid8, err8, busy8});
        end
        vectors++;
        if ({data16, valid16, err16, busy16} !== 11'd0) begin
            miscompares++;
            $display("FAIL reset16: outputs %03h, required 000", {data16, valid16, err16, busy16});
        end
        theresetn = 1'b1;
        repeat (5) @(posedge theclk);
    endtask

    task automatic test_single();
        int s0, e0, t0, lat;
        int exp_lat;
        exp_lat = SYNC + B8 / 2 + 9 * B8 + 1;
        s0 = strobe_cnt; e0 = err_cnt;
        strobe_cyc.delete();
        exp_q.push_back(8'h41);
        @(posedge theclk); #1;
        t0 = cyc;
        send_frame8(8'h41, 1'b1);
        #(BIT8_NS * 2);
        wait_drain(400);
        vectors++;
        if (strobe_cnt - s0 !== 1) begin
            miscompares++;
            $display("FAIL single_count: %0d strobes, required 1", strobe_cnt - s0);
        end
        lat = (strobe_cyc.size() > 0) ? strobe_cyc[0] - t0 : -1;
        vectors++;
        if (lat < exp_lat - 1 || lat > exp_lat + 1) begin
            miscompares++;
            $display("FAIL single_latency: %0d cycles, required %0d +-1", lat, exp_lat);
        end
        vectors++;
        if (err_cnt - e0 !== 0) begin
            miscompares++;
            $display("FAIL single_err: %0d frame_err, required 0", err_cnt - e0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] msg [3];
        int s0, gap;
        msg[0] = 8'h48; msg[1] = 8'h0D; msg[2] = 8'h0A;
        s0 = strobe_cnt;
        strobe_cyc.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(msg[i]);
        for (int i = 0; i < 3; i++) send_frame8(msg[i], 1'b1);
        #(BIT8_NS * 2);
        wait_drain(400);
        vectors++;
        if (strobe_cnt - s0 !== 3) begin
            miscompares++;
            $display("FAIL b2b_count: %0d strobes, required 3", strobe_cnt - s0);
        end
        for (int i = 1; i < 3; i++) begin
            gap = (strobe_cyc.size() > i) ? strobe_cyc[i] - strobe_cyc[i-1] : -1;
            vectors++;
            if (gap < 10 * B8 - 1 || gap > 10 * B8 + 1) begin
                miscompares++;
                $display("FAIL b2b_spacing%0d: %0d cycles, required %0d +-1", i, gap, 10 * B8);
            end
        end
    endtask

    task automatic test_glitch();
        int s0, e0, last;
        logic saw;
        s0 = strobe_cnt; e0 = err_cnt;
        @(posedge theclk); #1 rx8 = 1'b0;
        repeat (3) @(posedge theclk);
        #1 rx8 = 1'b1;
        saw = 1'b0; last = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge theclk);
            if (busy8) begin saw = 1'b1; last = i; end
        end
        vectors++;
        if (saw !== 1'b1) begin
            miscompares++;
            $display("FAIL glitch_busy_rise: rx_busy seen %0b, required 1", saw);
        end
        vectors++;
        if (last >= 8) begin
            miscompares++;
            $display("FAIL glitch_busy_fall: busy until cycle %0d, required < 8", last);
        end
        vectors++;
        if (strobe_cnt - s0 !== 0 || err_cnt - e0 !== 0) begin
            miscompares++;
            $display("FAIL glitch_out: %0d strobes %0d errs, required 0 0", strobe_cnt - s0, err_cnt - e0);
        end
    endtask

    task automatic test_frame_err();
        int s0, e0;
        s0 = strobe_cnt; e0 = err_cnt;
        send_frame8(8'h55, 1'b0);
        #(BIT8_NS * 50);
        rx8 = 1'b1;
        #(BIT8_NS * 2);
        exp_q.push_back(8'hA5);
        send_frame8(8'hA5, 1'b1);
        #(BIT8_NS * 2);
        wait_drain(400);
        vectors++;
        if (err_cnt - e0 !== 1) begin
            miscompares++;
            $display("FAIL break_errs: %0d frame_err, required 1", err_cnt - e0);
        end
        vectors++;
        if (strobe_cnt - s0 !== 1) begin
            miscompares++;
            $display("FAIL break_strobes: %0d strobes, required 1", strobe_cnt - s0);
        end
    endtask

    task automatic test_random();
        int s0, e0, gap;
        logic [7:0] b;
        s0 = strobe_cnt; e0 = err_cnt;
        for (int n = 0; n < 16; n++) begin
            b = 8'($urandom_range(0, 255));
            gap = $urandom_range(0, 2);
            exp_q.push_back(b);
            send_frame8(b, 1'b1);
            #(BIT8_NS * gap);
        end
        #(BIT8_NS * 2);
        wait_drain(400);
        vectors++;
        if (strobe_cnt - s0 !== 16 || err_cnt - e0 !== 0) begin
            miscompares++;
            $display("FAIL random_counts: %0d strobes %0d errs, required 16 0", strobe_cnt - s0, err_cnt - e0);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        logic busy_before;
        int s0, e0;
        b = 8'h3C;
        rx8 = 1'b0; #(BIT8_NS);
        for (int i = 0; i < 4; i++) begin
            rx8 = b[i]; #(BIT8_NS);
        end
        rx8 = b[4]; #(BIT8_NS / 2);
        @(posedge theclk); #3;
        busy_before = busy8;
        theresetn = 1'b0;
        #1;
        vectors++;
        if (busy_before !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_busy_before: rx_busy %0b, required 1", busy_before);
        end
        vectors++;
        if ({data8, valid8, err8, busy8} !== 11'd0) begin
            miscompares++;
            $display("FAIL midreset_async: outputs %03h, required 000", {data8, valid8, err8, busy8});
        end
        rx8 = 1'b1;
        #23 theresetn = 1'b1;
        repeat (3) @(posedge theclk);
        s0 = strobe_cnt; e0 = err_cnt;
        exp_q.push_back(8'h7E);
        send_frame8(8'h7E, 1'b1);
        #(BIT8_NS * 2);
        wait_drain(400);
        vectors++;
        if (strobe_cnt - s0 !== 1 || err_cnt - e0 !== 0) begin
            miscompares++;
            $display("FAIL midreset_after: %0d strobes %0d errs, required 1 0", strobe_cnt - s0, err_cnt - e0);
        end
    endtask

    task automatic test_skew();
        int s0, e0;
        s0 = strobe16_cnt; e0 = err16_cnt;
        exp16_q.push_back(8'h96);
        send_frame16(8'h96, 160.0 * 1.03);
        #320;
        exp16_q.push_back(8'h96);
        send_frame16(8'h96, 160.0 * 0.97);
        #320;
        wait_drain(400);
        vectors++;
        if (strobe16_cnt - s0 !== 2 || err16_cnt - e0 !== 0) begin
            miscompares++;
            $display("FAIL skew_counts: %0d strobes %0d errs, required 2 0", strobe16_cnt - s0, err16_cnt - e0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_random();
        test_reset_midframe();
        test_skew();
        repeat (10) @(posedge theclk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
Serial-to-parallel UART receiver (8N1, LSB first) that sits directly upstream of the simulation UART print monitor. It samples the raw TX line from the SoC UART pad and emits one byte per frame with a single-cycle valid strobe, on the same byte/valid interface the monitor consumes. It is synthesizable and is also instantiated in sim benches to decode the console.

Parameters:
BAUD_DIV, 434, theclk cycles per bit (50 MHz / 115200); legal range 4..65535.
SYNC_STAGES, 2, number of input synchronizer flops on rx; legal range 2..4.

Ports:
theclk  input  1  clock
theresetn  input  1  asynchronous active-low reset
rx  input  1  raw serial line, idle high, asynchronous to theclk
uart_data  output  8  received byte; valid only while uart_data_valid=1
uart_data_valid  output  1  one-cycle strobe per good frame
frame_err  output  1  one-cycle strobe when the stop bit samples low
rx_busy  output  1  high from start-bit detect until return to IDLE

Behaviour:
- Reset: theresetn is asynchronous and active-low; theclk is the only clock. All flops, including the synchronizer, reset on the theresetn falling edge without waiting for a clock edge. Synchronizer flops reset to 1. Reset values: uart_data=0x00, uart_data_valid=0, frame_err=0, rx_busy=0, state=IDLE, counters=0.
- rx passes through SYNC_STAGES flops. rx_s is the synchronizer output. All decisions use rx_s.
- Bit counter: tick counter width is $clog2(BAUD_DIV). Bit index is 3 bits. The shift register is 8 bits and shifts right, inserting the new bit at [7].
- IDLE: rx_busy=0. A low rx_s moves the FSM to START, loads the tick counter for a half-bit count of BAUD_DIV/2 (integer floor), and asserts rx_busy.
- START: when the half-bit count expires, sample rx_s.
  - rx_s=1: glitch. Return to IDLE with no output.
  - rx_s=0: go to DATA, reload the count to BAUD_DIV, and clear the bit index.
- DATA: each time BAUD_DIV elapses, shift rx_s in. After bit index 7, go to STOP and reload BAUD_DIV.
- STOP: when BAUD_DIV elapses, sample rx_s.
  - rx_s=1: in the next cycle, uart_data is set to the shift register and uart_data_valid=1 for exactly one cycle. The FSM returns to IDLE in that same cycle, so a new start bit can be detected right after the stop mid-point. Back-to-back frames therefore decode without loss.
  - rx_s=0: frame_err=1 for one cycle, no valid strobe, go to BREAK.
- BREAK: wait until rx_s=1, then go to IDLE. rx_busy stays 1 in BREAK. A line held low indefinitely produces exactly one frame_err.
- Latency: uart_data_valid rises 1 cycle after the stop-bit mid-sample. Relative to the rx start-bit falling edge, that is SYNC_STAGES + BAUD_DIV/2 + 9*BAUD_DIV + 1 cycles, ±1.
- Hold: uart_data holds its value between strobes and changes only at a strobe.
- Mutual exclusion: uart_data_valid and frame_err are never asserted together.
- Reset mid-frame: the partial byte is discarded and the FSM returns to IDLE. Because the synchronizer resets to 1, a line still low after reset release is treated as a new start edge. That can yield one garbage frame or one frame_err, which is accepted.
- No parity support and no FIFO. The downstream stage must accept one byte per strobe.

Test Plan:
- BAUD_DIV=8, send 0x41 with an ideal frame -> exactly one uart_data_valid pulse with uart_data=0x41 at the computed latency; frame_err stays 0.
- BAUD_DIV=8, back-to-back 0x48,0x0D,0x0A with no idle gap -> three strobes in order, 0x48, 0x0D, 0x0A, spaced 10*8 cycles apart ±1.
- rx low pulse of 3 cycles, below half-bit -> no strobe, no frame_err; rx_busy rises then returns to 0 before 8 cycles after the pulse.
- Frame 0x55 with the stop bit forced low, then line held low for 50 bits, then high, then a normal 0xA5 -> exactly one frame_err, no strobe for the bad frame, then uart_data=0xA5 with a valid strobe.
- Assert theresetn=0 asynchronously during data bit 4 of 0x3C -> all outputs 0 immediately, before the next clock edge. After release with the line idle high, send 0x7E -> uart_data=0x7E.
- Baud skew: transmit 0x96 at +3% and -3% bit period relative to BAUD_DIV=16 -> correct byte received both times.
